// File: rtl/fft_mag_mult_seq.sv
// Sequential shift-add multiplier stage behind the FFT butterfly sign decoder.
// Two lanes (real, imag) share one FSM and one iteration counter; each lane
// forms a signed 2n-bit product from an unsigned magnitude pair plus a sign flag.

// Per-lane shift-add datapath: holds operands, accumulator and signed product.
module fft_mag_mult_lane #(
  parameter int n  = 8,
  parameter int CW = 3
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load,
  input  logic           step,
  input  logic           last,
  input  logic [CW-1:0]  cnt,
  input  logic [n-1:0]   mb_in,
  input  logic [n-1:0]   mw_in,
  input  logic           neg_in,
  output logic [2*n-1:0] prod
);

  logic [n-1:0]   mb, mw;
  logic           neg;
  logic [2*n-1:0] acc, acc_nxt, addend;

  // Multiplier bit cnt selects whether the shifted multiplicand joins the sum.
  always_comb begin
    addend  = {{n{1'b0}}, mb} << cnt;
    acc_nxt = mw[cnt] ? acc + addend : acc;
  end

  // Operand latch on accept, one iteration per step, signed result on the last one.
  always_ff @(posedge clk) begin
    if (rst) begin
      mb   <= '0;
      mw   <= '0;
      neg  <= 1'b0;
      acc  <= '0;
      prod <= '0;
    end else if (load) begin
      mb  <= mb_in;
      mw  <= mw_in;
      neg <= neg_in;
      acc <= '0;
    end else if (step) begin
      acc <= acc_nxt;
      // Two's-complement negate; a zero magnitude stays exactly zero.
      if (last) prod <= neg ? (~acc_nxt + 1'b1) : acc_nxt;
    end
  end

endmodule

module fft_mag_mult_seq #(
  parameter int n = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [n-1:0]   REb,
  input  logic [n-1:0]   REw,
  input  logic [n-1:0]   IMb,
  input  logic [n-1:0]   IMw,
  input  logic           nMUL1,
  input  logic           nMUL2,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [2*n-1:0] PRe,
  output logic [2*n-1:0] PIm
);

  localparam int NUM_LANES = 2;
  localparam int CW        = (n > 1) ? $clog2(n) : 1;

  typedef enum logic [1:0] {IDLE, MUL, DONE} state_t;

  state_t  state, state_nxt;
  logic [CW-1:0] cnt;
  logic    load, step, last;

  // Lane 0 = real, lane 1 = imag.
  logic [NUM_LANES-1:0][n-1:0]   mb_in, mw_in;
  logic [NUM_LANES-1:0]          neg_in;
  logic [NUM_LANES-1:0][2*n-1:0] prod;

  assign mb_in  = {IMb, REb};
  assign mw_in  = {IMw, REw};
  assign neg_in = {nMUL2, nMUL1};
  assign last   = (cnt == CW'(n - 1));

  // State register and shared iteration counter.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      if (load)      cnt <= '0;
      else if (step) cnt <= cnt + 1'b1;
    end
  end

  // Next-state and handshake decode; no DONE->accept bypass.
  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    step      = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          load      = 1'b1;
          state_nxt = MUL;
        end
      end
      MUL: begin
        step = 1'b1;
        if (last) state_nxt = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  for (genvar g = 0; g < NUM_LANES; g++) begin : g_lane
    fft_mag_mult_lane #(.n(n), .CW(CW)) u_lane (
      .clk    (clk),
      .rst    (rst),
      .load   (load),
      .step   (step),
      .last   (last),
      .cnt    (cnt),
      .mb_in  (mb_in[g]),
      .mw_in  (mw_in[g]),
      .neg_in (neg_in[g]),
      .prod   (prod[g])
    );
  end

  assign PRe = prod[0];
  assign PIm = prod[1];

endmodule

// File: tb/tb_fft_mag_mult_seq.sv
// Scoreboard bench for fft_mag_mult_seq: expected products are pushed on
// accept and compared on the output handshake.
module tb_fft_mag_mult_seq;

  localparam int N = 8;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic           in_valid = 1'b0;
  logic           in_ready;
  logic [N-1:0]   REb = '0, REw = '0, IMb = '0, IMw = '0;
  logic           nMUL1 = 1'b0, nMUL2 = 1'b0;
  logic           out_valid;
  logic           out_ready = 1'b1;
  logic [2*N-1:0] PRe, PIm;

  typedef struct packed {
    logic [2*N-1:0] re;
    logic [2*N-1:0] im;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   acc_edge = -1;
  int   prev_acc = -1;
  bit   ov_prev = 1'b0;
  bit   stream = 1'b0;

  fft_mag_mult_seq #(.n(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .REb       (REb),
    .REw       (REw),
    .IMb       (IMb),
    .IMw       (IMw),
    .nMUL1     (nMUL1),
    .nMUL2     (nMUL2),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .PRe       (PRe),
    .PIm       (PIm)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // Signed reference: plain multiply of magnitudes, then negate if flagged.
  function automatic logic [2*N-1:0] mref(input logic [N-1:0] b, input logic [N-1:0] w,
                                         input logic neg);
    logic [2*N-1:0] p;
    p = (2*N)'(b) * (2*N)'(w);
    return neg ? (2*N)'(-p) : p;
  endfunction

  // Monitor: push on accept, pop on output handshake, track latency/interval.
  always @(negedge clk) begin
    if (!stream) prev_acc = -1;
    if (rst) begin
      sb.delete();
      ov_prev  = 1'b0;
      acc_edge = -1;
    end else begin
      if (in_valid && in_ready) begin
        sb.push_back('{re: mref(REb, REw, nMUL1), im: mref(IMb, IMw, nMUL2)});
        if (stream && prev_acc >= 0) chk("interval", 32'(cyc + 1 - prev_acc), N + 2);
        prev_acc = cyc + 1;
        acc_edge = cyc + 1;
      end
      if (out_valid && !ov_prev) chk("latency", 32'(cyc - acc_edge), N);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) chk("sb_underflow", 1, 0);
        else begin
          exp_t e;
          e = sb.pop_front();
          chk("PRe", 32'(PRe), 32'(e.re));
          chk("PIm", 32'(PIm), 32'(e.im));
        end
      end
      ov_prev = out_valid;
    end
  end

  // Called at posedge+1: step edges until one where in_ready was high beforehand.
  task automatic accept_wait();
    bit rdy;
    int k = 0;
    do begin
      rdy = in_ready;
      @(posedge clk); #1;
      k++;
    end while (!rdy && k < 50);
    if (!rdy) chk("accept_timeout", 0, 1);
  endtask

  task automatic issue(input logic [N-1:0] rb, input logic [N-1:0] rw, input logic n1,
                       input logic [N-1:0] ib, input logic [N-1:0] iw, input logic n2);
    REb = rb; REw = rw; nMUL1 = n1;
    IMb = ib; IMw = iw; nMUL2 = n2;
    in_valid = 1'b1;
    accept_wait();
    in_valid = 1'b0;
    // Scramble operands after the accept edge; the DUT must not notice.
    REb = N'($urandom); REw = N'($urandom); IMb = N'($urandom); IMw = N'($urandom);
    nMUL1 = 1'($urandom); nMUL2 = 1'($urandom);
  endtask

  task automatic wait_out();
    int k = 0;
    while (!out_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    if (!out_valid) chk("out_timeout", 0, 1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    // 1: reset with random inputs applied
    rst = 1'b1; in_valid = 1'b1;
    REb = N'($urandom); REw = N'($urandom); IMb = N'($urandom); IMw = N'($urandom);
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", 32'(in_ready), 1);
    chk("rst_out_valid", 32'(out_valid), 0);
    chk("rst_PRe", 32'(PRe), 0);
    chk("rst_PIm", 32'(PIm), 0);
    in_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk); #1;

    // 2: basic operation, includes 0x80*0x80 negated
    out_ready = 1'b1;
    issue(8'd25, 8'd3, 1'b0, 8'h80, 8'h80, 1'b1);
    wait_out();
    chk("t2_PRe", 32'(PRe), 32'h004B);
    chk("t2_PIm", 32'(PIm), 32'hC000);
    @(posedge clk); #1;

    // 3: zero product with sign flag, negative small product
    issue(8'd0, 8'h7F, 1'b1, 8'h7F, 8'd1, 1'b1);
    wait_out();
    chk("t3_PRe", 32'(PRe), 32'h0000);
    chk("t3_PIm", 32'(PIm), 32'hFF81);
    @(posedge clk); #1;

    // 4: backpressure while upstream toggles
    out_ready = 1'b0;
    issue(8'd100, 8'd77, 1'b1, 8'd128, 8'd3, 1'b0);
    wait_out();
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'($urandom);
      REb = N'($urandom); REw = N'($urandom); IMb = N'($urandom); IMw = N'($urandom);
      @(posedge clk); #1;
      chk("bp_PRe", 32'(PRe), 32'(mref(8'd100, 8'd77, 1'b1)));
      chk("bp_PIm", 32'(PIm), 32'(mref(8'd128, 8'd3, 1'b0)));
      chk("bp_out_valid", 32'(out_valid), 1);
      chk("bp_in_ready", 32'(in_ready), 0);
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_in_ready", 32'(in_ready), 1);
    chk("bp_release_out_valid", 32'(out_valid), 0);
    issue(8'd9, 8'd11, 1'b0, 8'd6, 8'd7, 1'b1);
    wait_out();
    @(posedge clk); #1;

    // 5: reset mid-operation, then a normal op
    issue(8'd10, 8'd10, 1'b0, 8'd3, 8'd3, 1'b0);
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_out_valid", 32'(out_valid), 0);
    chk("mid_rst_in_ready", 32'(in_ready), 1);
    chk("mid_rst_PRe", 32'(PRe), 0);
    rst = 1'b0;
    issue(8'd2, 8'd5, 1'b1, 8'd4, 8'd4, 1'b0);
    wait_out();
    chk("t5_PRe", 32'(PRe), 32'hFFF6);
    @(posedge clk); #1;

    // 6: streaming, handshakes held high
    stream = 1'b1;
    out_ready = 1'b1;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      REb = N'($urandom_range(0, 128)); REw = N'($urandom_range(0, 128));
      IMb = N'($urandom_range(0, 128)); IMw = N'($urandom_range(0, 128));
      nMUL1 = 1'($urandom); nMUL2 = 1'($urandom);
      accept_wait();
    end
    in_valid = 1'b0;
    begin
      int k = 0;
      while (sb.size() != 0 && k < 50) begin
        @(posedge clk); #1;
        k++;
      end
    end
    chk("sb_drained", 32'(sb.size()), 0);
    stream = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fft_mag_mult_seq.md
Name: fft_mag_mult_seq

Overview:
- Sequential shift-add multiplier stage that sits directly downstream of the FFT butterfly sign decoder.
- Consumes the decoder's magnitude pairs (real pair REb/REw, imaginary pair IMb/IMw) and the sign-flip flags nMUL1/nMUL2.
- Produces two signed 2n-bit products, PRe = ±REb·REw and PIm = ±IMb·IMw, for the butterfly add/sub stage.
- Uses valid/ready handshakes on both sides; one multiplication pair in flight at a time.

Parameters:
- n, 8, operand magnitude width. Magnitudes are unsigned 0..2^(n-1); the value 2^(n-1) arises from negating the most-negative input.

Ports:
- clk  input  1  system clock, all state on rising edge
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  upstream operands valid
- in_ready  output  1  stage can accept operands
- REb  input  n  real data magnitude, unsigned
- REw  input  n  real twiddle magnitude, unsigned
- IMb  input  n  imag data magnitude, unsigned
- IMw  input  n  imag twiddle magnitude, unsigned
- nMUL1  input  1  1 = real product is negative
- nMUL2  input  1  1 = imag product is negative
- out_valid  output  1  products valid
- out_ready  input  1  downstream accepts products
- PRe  output  2n  signed two's-complement real product
- PIm  output  2n  signed two's-complement imag product

Behaviour:
- Reset (rst=1 at a rising edge): state=IDLE, in_ready=1, out_valid=0, PRe=0, PIm=0, iteration counter=0, internal accumulators=0. Reset has priority over every other event.
- FSM states: IDLE, MUL, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid=1, latch REb, REw, IMb, IMw, nMUL1, nMUL2 and clear both accumulators and the counter. Next state is MUL.
  - Inputs are sampled only on this accept edge. Input changes at any other time have no effect.
- MUL:
  - in_ready=0, out_valid=0.
  - Each cycle performs one shift-add iteration on both multipliers in parallel, with a shared counter.
  - Multiplier operands are REw and IMw, examined LSB first. If the current bit is 1, add the left-shifted multiplicand (REb or IMb) to the 2n-bit unsigned accumulator.
  - After iteration n (counter = n-1 on that edge):
    - PRe = nMUL1 ? (~accRe + 1) : accRe, truncated to 2n bits.
    - PIm is formed the same way from accIm and nMUL2.
    - Next state is DONE.
  - in_valid during MUL is ignored.
- DONE:
  - out_valid=1, in_ready=0.
  - PRe/PIm are held stable while out_ready=0, for any number of cycles.
  - On out_ready=1 at an edge, next state is IDLE and out_valid drops to 0. PRe/PIm keep their last values and are don't-care while out_valid=0.
- Latency and throughput:
  - out_valid rises exactly n edges after the accept edge.
  - Minimum issue interval is n+2 cycles (accept, n iterations, handshake). There is no bypass from DONE directly to accept.
- Arithmetic:
  - Unsigned magnitude product ≤ 2^(2n-2), so the signed 2n-bit result never overflows (n=8: range -16384..16384).
  - A zero product with its flag set must yield exactly 0.
- Boundary cases:
  - Both operands 2^(n-1) (n=8: 0x80·0x80) gives 0x4000 before sign.
  - An operand of 0 terminates with a 0 product after the full n iterations; there is no early exit.
  - Reset in MUL or DONE abandons the operation and clears all state; the first post-reset accept behaves normally.

Test Plan:
1. Reset check: assert rst 2 cycles with random inputs -> in_ready=1, out_valid=0, PRe=0x0000, PIm=0x0000.
2. Basic operation, n=8: REb=25, REw=3, nMUL1=0; IMb=0x80, IMw=0x80, nMUL2=1; one in_valid pulse -> out_valid high exactly 8 edges after accept; PRe=0x004B (75); PIm=0xC000 (-16384).
3. Zero and sign cases: REb=0, REw=0x7F, nMUL1=1; IMb=0x7F, IMw=1, nMUL2=1 -> PRe=0x0000; PIm=0xFF81 (-127).
4. Backpressure: complete an op, hold out_ready=0 for 5 cycles while toggling in_valid and inputs -> PRe/PIm stable, out_valid=1, in_ready=0, no new accept. Release out_ready -> IDLE next edge, then the next op is accepted.
5. Reset mid-operation: accept REb=10, REw=10; assert rst after 3 MUL cycles -> next cycle IDLE with out_valid=0. Then run REb=2, REw=5, nMUL1=1 -> PRe=0xFFF6 (-10).
6. Streaming: in_valid and out_ready held at 1; 200 random magnitudes in 0..128 and random flags -> one result every 10 cycles (n+2), each matching a signed reference model exactly.
